// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and SPI mode encodings for spi_slave
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: single-bit multi-flop synchronizer with selectable reset value
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= {STAGES{rst_val}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, all four modes; SPI_SLAVE_MSB_FIRST_EN selects MSB-first
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              err
);
  import spi_pkg::*;
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, next;
  logic sclk_s, cs_s, mosi_s, sclk_d;
  logic cpol_l, cpha_l;
  logic lead, trail, sample, advance, last, consume;
  logic full, under, out_bit;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] tsr, rsr, shadow, tsr_adv, rsr_next;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .rst_val(1'b0), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_cs   (.clk(clk), .rst(rst), .rst_val(1'b1), .d(cs_n), .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .rst(rst), .rst_val(1'b0), .d(mosi), .q(mosi_s));

`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign out_bit  = tsr[DATA_W-1];
  assign tsr_adv  = {tsr[DATA_W-2:0], 1'b0};
  assign rsr_next = {rsr[DATA_W-2:0], mosi_s};
`else
  assign out_bit  = tsr[0];
  assign tsr_adv  = {1'b0, tsr[DATA_W-1:1]};
  assign rsr_next = {mosi_s, rsr[DATA_W-1:1]};
`endif

  // leading edge leaves the latched idle level, trailing edge returns to it
  assign lead    = cpol_l ? (sclk_d & ~sclk_s) : (~sclk_d & sclk_s);
  assign trail   = cpol_l ? (~sclk_d & sclk_s) : (sclk_d & ~sclk_s);
  assign sample  = (state == SHIFT) && !cs_s && (cpha_l ? trail : lead);
  // bit 0 is already on the wire from the load, so shifting starts after the first sample
  assign advance = (state == SHIFT) && !cs_s && (cnt != '0) && (cpha_l ? lead : trail);
  assign last    = sample && (cnt == CW'(DATA_W - 1));
  assign consume = (state == LOAD) || ((state == DONE) && !cs_s);
  assign busy     = (state != IDLE);
  assign miso_oe  = busy;
  assign miso     = busy & out_bit;
  assign tx_ready = ~full;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;

  // next-state logic; cs_n high in SHIFT ends or aborts the frame
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = cs_s ? IDLE : LOAD;
      LOAD:    next = SHIFT;
      SHIFT:   next = cs_s ? IDLE : (last ? DONE : SHIFT);
      DONE:    next = cs_s ? IDLE : SHIFT;
      default: next = IDLE;
    endcase
  end

  // transmit shadow: a same-cycle load lands after the copy into the shift register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      full   <= 1'b0;
    end else begin
      if (consume) begin
        shadow <= '0;
        full   <= 1'b0;
      end
      if (tx_load && !full) begin
        shadow <= tx_data;
        full   <= 1'b1;
      end
    end

  // shift datapath, mode latch, received word and status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_d   <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      cnt      <= '0;
      tsr      <= '0;
      rsr      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
      under    <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      rx_valid <= (state == DONE);
      err      <= ((state == LOAD) && !full) ||
                  ((state == SHIFT) && cs_s && (cnt != '0)) ||
                  (sample && under);
      if (state == IDLE) begin
        cpol_l <= cpol;
        cpha_l <= cpha;
        under  <= 1'b0;
      end
      if (consume) begin
        tsr   <= full ? shadow : '0;
        cnt   <= '0;
        under <= (state == DONE) && !full;
      end
      if (sample) begin
        rsr   <= rsr_next;
        cnt   <= cnt + 1'b1;
        under <= 1'b0;
      end
      if (advance) tsr <= tsr_adv;
      if (state == DONE) rx_data <= rsr;
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master bench for spi_slave with hand-computed expectations
module tb_spi_slave;
  import spi_pkg::*;
  localparam int W = 8;
  localparam int H = 80;
  logic clk = 1'b0, rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_load = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic miso, miso_oe, tx_ready, rx_valid, busy, err;
  logic [W-1:0] rx_data;
  int n_vec = 0, n_miss = 0, rxv_cnt = 0, err_cnt = 0;
  logic [W-1:0] rx_log [16];
  logic busy_mid;

  spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rxv_cnt[3:0]] = rx_data;
      rxv_cnt++;
    end
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int i);
`ifdef SPI_SLAVE_MSB_FIRST_EN
    return W - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic load(input logic [W-1:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic xfer(input logic [1:0] mode, input logic [W-1:0] tx, input int nbits,
                      input bit start, input bit stop, output logic [W-1:0] rx);
    rx = '0;
    if (start) begin
      {cpol, cpha} = mode;
      sclk = mode[1];
      #(H);
      cs_n = 1'b0;
      #(H);
    end
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[idx(i)];
        #(H);
        rx[idx(i)] = miso;
        sclk = ~cpol;
        #(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = tx[idx(i)];
        #(H);
        rx[idx(i)] = miso;
        sclk = cpol;
        #(H);
      end
      if (i == 3) busy_mid = busy;
    end
    if (stop) begin
      #(H);
      cs_n = 1'b1;
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_miso"}, 32'(miso), 0);
    check({pfx, "_miso_oe"}, 32'(miso_oe), 0);
    check({pfx, "_rx_data"}, 32'(rx_data), 0);
    check({pfx, "_rx_valid"}, 32'(rx_valid), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_tx_ready"}, 32'(tx_ready), 1);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got, got2;
    int rv0, e0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    load(8'hA5);
    check("m0_tx_ready_low", 32'(tx_ready), 0);
    rv0 = rxv_cnt; e0 = err_cnt;
    xfer(MODE0, 8'h3C, W, 1, 1, got);
    settle();
    check("m0_rx_data", 32'(rx_data), 32'h3C);
    check("m0_rx_valid_cycles", 32'(rxv_cnt - rv0), 1);
    check("m0_master_rx", 32'(got), 32'hA5);
    check("m0_err", 32'(err_cnt - e0), 0);
    check("m0_tx_ready", 32'(tx_ready), 1);

    for (int k = 1; k < 4; k++) begin
      load(8'h81);
      check($sformatf("m%0d_busy_before", k), 32'(busy), 0);
      rv0 = rxv_cnt;
      xfer(2'(k), 8'h7E, W, 1, 1, got);
      check($sformatf("m%0d_busy_mid", k), 32'(busy_mid), 1);
      settle();
      check($sformatf("m%0d_busy_after", k), 32'(busy), 0);
      check($sformatf("m%0d_rx_data", k), 32'(rx_data), 32'h7E);
      check($sformatf("m%0d_master_rx", k), 32'(got), 32'h81);
      check($sformatf("m%0d_rx_valid_cycles", k), 32'(rxv_cnt - rv0), 1);
    end

    load(8'h5A);
    rv0 = rxv_cnt; e0 = err_cnt;
    xfer(MODE0, 8'hFF, 5, 1, 1, got);
    settle();
    check("abort_err", 32'(err_cnt - e0), 1);
    check("abort_rx_valid", 32'(rxv_cnt - rv0), 0);
    check("abort_rx_data_kept", 32'(rx_data), 32'h7E);
    check("abort_busy", 32'(busy), 0);
    load(8'hC3);
    rv0 = rxv_cnt; e0 = err_cnt;
    xfer(MODE0, 8'h96, W, 1, 1, got);
    settle();
    check("post_abort_rx_data", 32'(rx_data), 32'h96);
    check("post_abort_master_rx", 32'(got), 32'hC3);
    check("post_abort_err", 32'(err_cnt - e0), 0);

    load(8'h55);
    rv0 = rxv_cnt; e0 = err_cnt;
    fork
      begin
        xfer(MODE0, 8'h11, W, 1, 0, got);
        xfer(MODE0, 8'h22, W, 0, 1, got2);
      end
      begin
        #(H * 6);
        load(8'h66);
      end
    join
    settle();
    check("b2b_rx_valid_count", 32'(rxv_cnt - rv0), 2);
    check("b2b_first_rx", 32'(rx_log[rv0[3:0]]), 32'h11);
    check("b2b_second_rx", 32'(rx_data), 32'h22);
    check("b2b_master_rx1", 32'(got), 32'h55);
    check("b2b_master_rx2", 32'(got2), 32'h66);
    check("b2b_err", 32'(err_cnt - e0), 0);

    rv0 = rxv_cnt; e0 = err_cnt;
    check("under_tx_ready", 32'(tx_ready), 1);
    xfer(MODE0, 8'hE7, W, 1, 1, got);
    settle();
    check("under_err", 32'(err_cnt - e0), 1);
    check("under_master_rx", 32'(got), 0);
    check("under_rx_data", 32'(rx_data), 32'hE7);

    load(8'h99);
    fork
      xfer(MODE1, 8'h42, W, 1, 1, got);
      begin
        repeat (40) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check_reset("midrst");
      end
    join
    rst = 1'b0;
    settle();
    check("post_rst_tx_ready", 32'(tx_ready), 1);
    check("post_rst_rx_data", 32'(rx_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
